ft245_sync_responder: RTL and testbench

Device-side model of the FT245 synchronous FIFO interface, the FTDI-chip end of the link that the host bridge drives. It presents `rde_n`/`txe_n` flags and read data to a host master. It accepts host writes into a receive buffer and sources host reads from a transmit buffer filled by user logic. It is synthesizable and is used for on-FPGA loopback and as the bench partner for the host bridge.

---
 rtl/ft245_pkg.sv | 13 +
 rtl/ft245_sync_fifo_buf.sv | 80 ++++++++
 rtl/ft245_sync_responder.sv | 152 +++++++++++++++
 tb/tb_ft245_sync_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 synchronous FIFO device model: bus width,
// default FIFO depth and the bit positions of the sticky error flags.
package ft245_pkg;

  localparam int FT245_DW         = 8;
  localparam int FT245_DEFAULT_AW = 9;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_PROTOCOL = 2;
  localparam int ERR_COUNT    = 3;

endpackage

// File: rtl/ft245_sync_fifo_buf.sv
// Single-clock show-ahead FIFO. Push and pop may happen in the same cycle; a
// push into a full buffer is accepted when a pop frees a slot on that edge.
// head_next is the byte at the head once this edge's push/pop has settled
// (0x00 when the buffer will be empty), so callers can register it directly.
module ft245_sync_fifo_buf
  import ft245_pkg::*;
#(
  parameter int ADDR_WIDTH = FT245_DEFAULT_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FT245_DW-1:0]   push_data,
  input  logic                  pop,
  output logic [FT245_DW-1:0]   head_next,
  output logic [ADDR_WIDTH:0]   count_next,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [FT245_DW-1:0]   mem [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  do_push;
  logic                  do_pop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign do_pop      = pop & ~empty;
  assign do_push     = push & (~full | do_pop);
  assign rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign remaining   = count - {{ADDR_WIDTH{1'b0}}, do_pop};

  // Next occupancy and next head byte; a push into a buffer that the pop has
  // just drained bypasses memory because that slot is written on this edge.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
    head_next = '0;
    if (count_next != '0) begin
      if (remaining == '0) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  // Pointer and count state; pointers wrap naturally at the depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ft245_sync_responder.sv
// Device end of an FT245 synchronous FIFO link. Host writes land in rx_q for
// the user; user bytes in tx_q are served to host reads. Optional idle-suspend
// detection is built only when FT245_SUSPEND_EN is defined.
module ft245_sync_responder
  import ft245_pkg::*;
#(
  parameter int          ADDR_WIDTH   = FT245_DEFAULT_AW,
  parameter logic [15:0] SUSPEND_IDLE = 16'd1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FT245_DW-1:0] ftdi_data_in,
  output logic [FT245_DW-1:0] ftdi_data_out,
  output logic                ftdi_data_oe,
  output logic                ftdi_rde_n,
  output logic                ftdi_txe_n,
  input  logic                ftdi_rd_n,
  input  logic                ftdi_oe_n,
  input  logic                ftdi_wr_n,
  input  logic                ftdi_siwu,
  output logic                ftdi_suspend_n,
  input  logic                dev_in_valid,
  output logic                dev_in_ready,
  input  logic [FT245_DW-1:0] dev_in_data,
  output logic                dev_out_valid,
  input  logic                dev_out_ready,
  output logic [FT245_DW-1:0] dev_out_data,
  output logic                err_underrun,
  output logic                err_overrun,
  output logic                err_protocol
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [FT245_DW-1:0]  tx_head_next;
  logic [FT245_DW-1:0]  rx_head_next;
  logic [ADDR_WIDTH:0]  tx_count_next;
  logic [ADDR_WIDTH:0]  rx_count_next;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 bus_conflict;
  logic                 rd_strobe;
  logic                 host_rd;
  logic                 host_wr;
  logic [ERR_COUNT-1:0] err_flags;

  assign ftdi_data_oe  = ~ftdi_oe_n;
  assign dev_in_ready  = rst_n & ~tx_full;
  assign dev_out_valid = rst_n & ~rx_empty;
  assign bus_conflict  = ~ftdi_oe_n & ~ftdi_wr_n;
  assign rd_strobe     = ~ftdi_oe_n & ~ftdi_rd_n;
  assign host_rd       = rd_strobe & ~ftdi_rde_n & ~tx_empty & ~bus_conflict;
  assign host_wr       = ~ftdi_wr_n & ~ftdi_txe_n & ~rx_full & ~bus_conflict;

  ft245_sync_fifo_buf #(.ADDR_WIDTH(ADDR_WIDTH)) tx_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (dev_in_valid),
    .push_data  (dev_in_data),
    .pop        (host_rd),
    .head_next  (tx_head_next),
    .count_next (tx_count_next),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  ft245_sync_fifo_buf #(.ADDR_WIDTH(ADDR_WIDTH)) rx_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (host_wr),
    .push_data  (ftdi_data_in),
    .pop        (dev_out_ready),
    .head_next  (rx_head_next),
    .count_next (rx_count_next),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  // Bus flags and head bytes registered from the post-edge FIFO state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ftdi_rde_n    <= 1'b1;
      ftdi_txe_n    <= 1'b1;
      ftdi_data_out <= '0;
      dev_out_data  <= '0;
    end else begin
      ftdi_rde_n    <= (tx_count_next == '0);
      ftdi_txe_n    <= (rx_count_next == DEPTH_CNT);
      ftdi_data_out <= tx_head_next;
      dev_out_data  <= rx_head_next;
    end
  end

  // Sticky host-misuse flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_flags <= '0;
    end else begin
      if (rd_strobe && ftdi_rde_n) begin
        err_flags[ERR_UNDERRUN] <= 1'b1;
      end
      if (!ftdi_wr_n && ftdi_txe_n) begin
        err_flags[ERR_OVERRUN] <= 1'b1;
      end
      if (bus_conflict || (!ftdi_rd_n && ftdi_oe_n)) begin
        err_flags[ERR_PROTOCOL] <= 1'b1;
      end
    end
  end

  assign err_underrun = err_flags[ERR_UNDERRUN];
  assign err_overrun  = err_flags[ERR_OVERRUN];
  assign err_protocol = err_flags[ERR_PROTOCOL];

`ifdef FT245_SUSPEND_EN
  logic [15:0] idle_count;
  logic [15:0] idle_count_next;
  logic        any_strobe;
  logic        suspend_n_q;

  assign any_strobe = ~ftdi_rd_n | ~ftdi_oe_n | ~ftdi_wr_n | ~ftdi_siwu;

  // Saturating idle counter; any strobe activity restarts it.
  always_comb begin
    idle_count_next = idle_count;
    if (any_strobe) begin
      idle_count_next = '0;
    end else if (idle_count != 16'hFFFF) begin
      idle_count_next = idle_count + 16'd1;
    end
  end

  // Suspend pin follows the counter; host accesses are not blocked by it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_count  <= '0;
      suspend_n_q <= 1'b1;
    end else begin
      idle_count  <= idle_count_next;
      suspend_n_q <= (idle_count_next < SUSPEND_IDLE);
    end
  end

  assign ftdi_suspend_n = suspend_n_q;
`else
  // Without idle detection the bus never suspends; siwu has no effect.
  assign ftdi_suspend_n = 1'b1 | ftdi_siwu;
`endif

endmodule

// File: tb/tb_ft245_sync_responder.sv
// Self-checking bench for ft245_sync_responder. A queue-based model of both
// byte streams plus sticky error bits predicts every output. Define
// FT245_SUSPEND_EN to exercise idle-suspend detection.
module tb_ft245_sync_responder;

  localparam int DEPTH = 512;

  logic       clk;
  logic       rst_n;
  logic [7:0] ftdi_data_in;
  logic [7:0] ftdi_data_out;
  logic       ftdi_data_oe;
  logic       ftdi_rde_n;
  logic       ftdi_txe_n;
  logic       ftdi_rd_n;
  logic       ftdi_oe_n;
  logic       ftdi_wr_n;
  logic       ftdi_siwu;
  logic       ftdi_suspend_n;
  logic       dev_in_valid;
  logic       dev_in_ready;
  logic [7:0] dev_in_data;
  logic       dev_out_valid;
  logic       dev_out_ready;
  logic [7:0] dev_out_data;
  logic       err_underrun;
  logic       err_overrun;
  logic       err_protocol;

  int checks;
  int passes;

  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit         m_underrun;
  bit         m_overrun;
  bit         m_protocol;

  ft245_sync_responder #(.ADDR_WIDTH(9), .SUSPEND_IDLE(16'd20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ftdi_data_in   (ftdi_data_in),
    .ftdi_data_out  (ftdi_data_out),
    .ftdi_data_oe   (ftdi_data_oe),
    .ftdi_rde_n     (ftdi_rde_n),
    .ftdi_txe_n     (ftdi_txe_n),
    .ftdi_rd_n      (ftdi_rd_n),
    .ftdi_oe_n      (ftdi_oe_n),
    .ftdi_wr_n      (ftdi_wr_n),
    .ftdi_siwu      (ftdi_siwu),
    .ftdi_suspend_n (ftdi_suspend_n),
    .dev_in_valid   (dev_in_valid),
    .dev_in_ready   (dev_in_ready),
    .dev_in_data    (dev_in_data),
    .dev_out_valid  (dev_out_valid),
    .dev_out_ready  (dev_out_ready),
    .dev_out_data   (dev_out_data),
    .err_underrun   (err_underrun),
    .err_overrun    (err_overrun),
    .err_protocol   (err_protocol)
  );

  // Free-running bus clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of stimulus, lets one edge pass, and advances the model
  // by the stream rules: host pop needs a byte, host push needs room, and a
  // user push on a full tx stream is taken only when the host pops that edge.
  task automatic applyStimulus(input bit rd, input bit oe, input bit wr, input bit vin,
                               input logic [7:0] din, input bit rdy, input logic [7:0] hdata);
    bit conflict, hpop, hpush, upush, upop;
    ftdi_rd_n     = rd;
    ftdi_oe_n     = oe;
    ftdi_wr_n     = wr;
    dev_in_valid  = vin;
    dev_in_data   = din;
    dev_out_ready = rdy;
    ftdi_data_in  = hdata;
    conflict = !oe && !wr;
    hpop     = !oe && !rd && (tx_m.size() > 0) && !conflict;
    hpush    = !wr && (rx_m.size() < DEPTH) && !conflict;
    upush    = vin && ((tx_m.size() < DEPTH) || hpop);
    upop     = rdy && (rx_m.size() > 0);
    if (!oe && !rd && tx_m.size() == 0) m_underrun = 1'b1;
    if (!wr && rx_m.size() == DEPTH) m_overrun = 1'b1;
    if (conflict || (!rd && oe)) m_protocol = 1'b1;
    @(posedge clk);
    #1;
    if (hpop) void'(tx_m.pop_front());
    if (upush) tx_m.push_back(din);
    if (upop) void'(rx_m.pop_front());
    if (hpush) rx_m.push_back(hdata);
  endtask

  // Holds reset for two edges and empties the model; optionally passes the
  // release edge so the host may write afterwards.
  task automatic applyReset(input bit settle);
    rst_n = 1'b0;
    ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b1; ftdi_wr_n = 1'b1; ftdi_siwu = 1'b1;
    dev_in_valid = 1'b0; dev_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_m.delete();
    rx_m.delete();
    m_underrun = 1'b0; m_overrun = 1'b0; m_protocol = 1'b0;
    rst_n = 1'b1;
    if (settle) applyStimulus(1, 1, 1, 0, 8'h00, 0, 8'h00);
  endtask

  // Reset values, then host-writable one edge after release.
  task automatic test_reset();
    applyReset(0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({ftdi_rde_n, ftdi_txe_n} !== 2'b11) $display("[TB] FAIL reset_flags: got %b, expected 11", {ftdi_rde_n, ftdi_txe_n}); else passes++;
    checks++; if (ftdi_data_out !== 8'h00) $display("[TB] FAIL reset_data_out: got %h, expected 00", ftdi_data_out); else passes++;
    checks++; if (ftdi_suspend_n !== 1'b1) $display("[TB] FAIL reset_suspend_n: got %b, expected 1", ftdi_suspend_n); else passes++;
    checks++; if ({err_underrun, err_overrun, err_protocol} !== 3'b000) $display("[TB] FAIL reset_errors: got %b, expected 000", {err_underrun, err_overrun, err_protocol}); else passes++;
    checks++; if ({dev_in_ready, dev_out_valid} !== 2'b00) $display("[TB] FAIL reset_user_handshake: got %b, expected 00", {dev_in_ready, dev_out_valid}); else passes++;
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 0, 8'h00, 0, 8'h00);
    checks++; if ({ftdi_rde_n, ftdi_txe_n} !== 2'b10) $display("[TB] FAIL release_flags: got %b, expected 10", {ftdi_rde_n, ftdi_txe_n}); else passes++;
    checks++; if ({err_underrun, err_overrun, err_protocol, dev_in_ready} !== 4'b0001) $display("[TB] FAIL release_err_ready: got %b, expected 0001", {err_underrun, err_overrun, err_protocol, dev_in_ready}); else passes++;
  endtask

  // User pushes two bytes; host reads them back at one byte per cycle.
  task automatic test_read_path();
    applyReset(1);
    applyStimulus(1, 1, 1, 1, 8'hA5, 0, 8'h00);
    applyStimulus(1, 1, 1, 1, 8'h3C, 0, 8'h00);
    checks++; if ({ftdi_rde_n, ftdi_data_out} !== {1'b0, 8'hA5}) $display("[TB] FAIL read_first_ready: got %b/%h, expected 0/a5", ftdi_rde_n, ftdi_data_out); else passes++;
    applyStimulus(1, 0, 1, 0, 8'h00, 0, 8'h00);
    checks++; if ({ftdi_data_oe, ftdi_data_out} !== {1'b1, 8'hA5}) $display("[TB] FAIL read_oe_only: got %b/%h, expected 1/a5", ftdi_data_oe, ftdi_data_out); else passes++;
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'h00);
    checks++; if ({ftdi_rde_n, ftdi_data_out} !== {1'b0, 8'h3C}) $display("[TB] FAIL read_second_byte: got %b/%h, expected 0/3c", ftdi_rde_n, ftdi_data_out); else passes++;
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'h00);
    checks++; if ({ftdi_rde_n, ftdi_data_out} !== {1'b1, 8'h00}) $display("[TB] FAIL read_drained: got %b/%h, expected 1/00", ftdi_rde_n, ftdi_data_out); else passes++;
    checks++; if ({err_underrun, err_protocol} !== 2'b00) $display("[TB] FAIL read_no_errors: got %b, expected 00", {err_underrun, err_protocol}); else passes++;
  endtask

  // Host fills rx with 512 bytes, overruns once, then the user drains it.
  task automatic test_rx_fill();
    int bad;
    int first_bad;
    applyReset(1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 1, 0, 0, 8'h00, 0, i[7:0]);
      if (i == DEPTH - 2) begin
        checks++; if (ftdi_txe_n !== 1'b0) $display("[TB] FAIL fill_511_txe_n: got %b, expected 0", ftdi_txe_n); else passes++;
      end
    end
    checks++; if ({ftdi_txe_n, dev_out_valid, dev_out_data} !== {2'b11, 8'h00}) $display("[TB] FAIL fill_512_state: got %b%b/%h, expected 11/00", ftdi_txe_n, dev_out_valid, dev_out_data); else passes++;
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'hEE);
    checks++; if ({err_overrun, err_protocol} !== 2'b10) $display("[TB] FAIL overrun_flag: got %b, expected 10", {err_overrun, err_protocol}); else passes++;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (dev_out_valid !== 1'b1 || dev_out_data !== i[7:0]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      applyStimulus(1, 1, 1, 0, 8'h00, 1, 8'h00);
    end
    checks++; if (bad != 0) $display("[TB] FAIL drain_order: got %0d bad bytes (first at %0d), expected 0", bad, first_bad); else passes++;
    checks++; if ({dev_out_valid, ftdi_txe_n} !== 2'b00) $display("[TB] FAIL drain_empty: got %b, expected 00", {dev_out_valid, ftdi_txe_n}); else passes++;
  endtask

  // Strobe misuse: oe+wr together, rd without oe, read of empty, siwu pulse.
  task automatic test_protocol();
    applyReset(1);
    applyStimulus(1, 1, 1, 1, 8'h5A, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h77);
    checks++; if ({err_protocol, err_underrun, err_overrun} !== 3'b100) $display("[TB] FAIL oe_wr_errors: got %b, expected 100", {err_protocol, err_underrun, err_overrun}); else passes++;
    checks++; if ({ftdi_rde_n, ftdi_data_out, dev_out_valid} !== {1'b0, 8'h5A, 1'b0}) $display("[TB] FAIL oe_wr_no_access: got %b/%h/%b, expected 0/5a/0", ftdi_rde_n, ftdi_data_out, dev_out_valid); else passes++;
    applyReset(1);
    applyStimulus(1, 1, 1, 1, 8'h11, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'h00);
    checks++; if ({err_protocol, ftdi_rde_n, ftdi_data_out} !== {2'b10, 8'h11}) $display("[TB] FAIL rd_without_oe: got %b%b/%h, expected 10/11", err_protocol, ftdi_rde_n, ftdi_data_out); else passes++;
    applyReset(1);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'h00);
    checks++; if ({err_underrun, err_protocol, ftdi_rde_n} !== 3'b101) $display("[TB] FAIL underrun_flag: got %b, expected 101", {err_underrun, err_protocol, ftdi_rde_n}); else passes++;
    applyReset(1);
    ftdi_siwu = 1'b0;
    applyStimulus(1, 1, 1, 0, 8'h00, 0, 8'h00);
    ftdi_siwu = 1'b1;
    checks++; if ({err_underrun, err_overrun, err_protocol, ftdi_rde_n, ftdi_txe_n} !== 5'b00010) $display("[TB] FAIL siwu_no_effect: got %b, expected 00010", {err_underrun, err_overrun, err_protocol, ftdi_rde_n, ftdi_txe_n}); else passes++;
  endtask

  // Full tx: user push and host pop on the same edge both proceed.
  task automatic test_full_tx_simul();
    logic [7:0] first_b, second_b, extra_b, last_seen;
    int bad;
    applyReset(1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 1, 1, 1, 8'($urandom), 0, 8'h00);
    end
    first_b  = tx_m[0];
    second_b = tx_m[1];
    checks++; if ({dev_in_ready, ftdi_rde_n, ftdi_data_out} !== {2'b00, first_b}) $display("[TB] FAIL tx_full_state: got %b%b/%h, expected 00/%h", dev_in_ready, ftdi_rde_n, ftdi_data_out, first_b); else passes++;
    extra_b = 8'($urandom);
    applyStimulus(0, 0, 1, 1, extra_b, 0, 8'h00);
    checks++; if ({dev_in_ready, ftdi_data_out} !== {1'b0, second_b}) $display("[TB] FAIL simul_push_pop: got %b/%h, expected 0/%h", dev_in_ready, ftdi_data_out, second_b); else passes++;
    bad = 0;
    last_seen = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (ftdi_rde_n !== 1'b0 || ftdi_data_out !== tx_m[0]) bad++;
      last_seen = ftdi_data_out;
      applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'h00);
    end
    checks++; if (bad != 0) $display("[TB] FAIL tx_drain_order: got %0d bad bytes, expected 0", bad); else passes++;
    checks++; if ({ftdi_rde_n, last_seen} !== {1'b1, extra_b}) $display("[TB] FAIL tx_last_byte: got %b/%h, expected 1/%h", ftdi_rde_n, last_seen, extra_b); else passes++;
  endtask

  // Random mixed traffic against the model, aggregated per output group.
  task automatic test_random();
    int bad_flags, bad_dout, bad_user, bad_err;
    int first_cycle;
    bit rd, oe, wr;
    int mode;
    applyReset(1);
    bad_flags = 0; bad_dout = 0; bad_user = 0; bad_err = 0; first_cycle = -1;
    for (int c = 0; c < 3000; c++) begin
      mode = $urandom_range(0, 9);
      rd = 1; oe = 1; wr = 1;
      if (mode >= 3 && mode <= 5) begin rd = 0; oe = 0; end
      else if (mode == 6 || mode == 7) wr = 0;
      else if (mode == 8) oe = 0;
      else if (mode == 9) begin rd = 1'($urandom); oe = 1'($urandom); wr = 1'($urandom); end
      applyStimulus(rd, oe, wr, 1'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom));
      if ({ftdi_rde_n, ftdi_txe_n} !== {tx_m.size() == 0, rx_m.size() == DEPTH}) begin
        bad_flags++; if (first_cycle < 0) first_cycle = c;
      end
      if (ftdi_data_out !== ((tx_m.size() > 0) ? tx_m[0] : 8'h00)) begin
        bad_dout++; if (first_cycle < 0) first_cycle = c;
      end
      if ({dev_in_ready, dev_out_valid} !== {tx_m.size() < DEPTH, rx_m.size() > 0} ||
          (rx_m.size() > 0 && dev_out_data !== rx_m[0])) begin
        bad_user++; if (first_cycle < 0) first_cycle = c;
      end
      if ({err_underrun, err_overrun, err_protocol} !== {m_underrun, m_overrun, m_protocol}) begin
        bad_err++; if (first_cycle < 0) first_cycle = c;
      end
    end
    checks++; if (bad_flags != 0) $display("[TB] FAIL random_flags: got %0d bad cycles (first %0d), expected 0", bad_flags, first_cycle); else passes++;
    checks++; if (bad_dout != 0) $display("[TB] FAIL random_data_out: got %0d bad cycles (first %0d), expected 0", bad_dout, first_cycle); else passes++;
    checks++; if (bad_user != 0) $display("[TB] FAIL random_user_side: got %0d bad cycles (first %0d), expected 0", bad_user, first_cycle); else passes++;
    checks++; if (bad_err != 0) $display("[TB] FAIL random_errors: got %0d bad cycles (first %0d), expected 0", bad_err, first_cycle); else passes++;
  endtask

  // Idle-suspend behaviour; without the feature the pin never drops.
  task automatic test_suspend();
    applyReset(1);
`ifdef FT245_SUSPEND_EN
    repeat (18) applyStimulus(1, 1, 1, 0, 8'h00, 0, 8'h00);
    checks++; if (ftdi_suspend_n !== 1'b1) $display("[TB] FAIL suspend_19_idle: got %b, expected 1", ftdi_suspend_n); else passes++;
    applyStimulus(1, 1, 1, 0, 8'h00, 0, 8'h00);
    checks++; if (ftdi_suspend_n !== 1'b0) $display("[TB] FAIL suspend_20_idle: got %b, expected 0", ftdi_suspend_n); else passes++;
    applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'h00);
    checks++; if (ftdi_suspend_n !== 1'b1) $display("[TB] FAIL suspend_wake: got %b, expected 1", ftdi_suspend_n); else passes++;
`else
    repeat (30) applyStimulus(1, 1, 1, 0, 8'h00, 0, 8'h00);
    checks++; if (ftdi_suspend_n !== 1'b1) $display("[TB] FAIL suspend_tied_high: got %b, expected 1", ftdi_suspend_n); else passes++;
`endif
  endtask

  // Test sequence and summary.
  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    ftdi_data_in = 8'h00; dev_in_data = 8'h00;
    ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b1; ftdi_wr_n = 1'b1; ftdi_siwu = 1'b1;
    dev_in_valid = 1'b0; dev_out_ready = 1'b0;
    test_reset();
    test_read_path();
    test_rx_fill();
    test_protocol();
    test_full_tx_simul();
    test_random();
    test_suspend();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
